// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and default parameters for the APB requester arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Command port towards the APB master plus the bus monitor signals used for completion.
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              PTX;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic              PSEL;
    logic              PENABLE;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output PTX, WRITE, ADDR, WDATA,
        input  PSEL, PENABLE, PREADY, PRDATA
    );

    modport slave (
        input  PTX, WRITE, ADDR, WDATA,
        output PSEL, PENABLE, PREADY, PRDATA
    );
endinterface

// File: rtl/apb_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N_REQ.
module apb_rr_pick
    import apb_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = $clog2(DEF_N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] index,
    output logic             any
);
    logic [PTR_W:0]   w_sum  [N_REQ];
    logic [PTR_W-1:0] w_cand [N_REQ];
    logic [N_REQ-1:0] w_hit;

    // Candidate gi is (ptr + gi + 1) mod N_REQ; ptr < N_REQ so one subtraction suffices.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign w_sum[gi]  = {1'b0, ptr} + (PTR_W+1)'(gi + 1);
        assign w_cand[gi] = (w_sum[gi] >= (PTR_W+1)'(N_REQ))
                          ? PTR_W'(w_sum[gi] - (PTR_W+1)'(N_REQ))
                          : w_sum[gi][PTR_W-1:0];
        assign w_hit[gi]  = req[w_cand[gi]];
    end

    always_comb begin
        index = '0;
        any   = |w_hit;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                index = w_cand[k];
            end
        end
        winner = any ? (N_REQ'(1) << index) : '0;
    end
endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port among N_REQ requesters,
// one transfer outstanding, with a per-transfer PREADY timeout.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    apb_req_arbiter_if.master        bus
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        r_state, w_state_next;
    logic [PTR_W-1:0]  r_ptr, w_ptr_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [N_REQ-1:0]  r_gnt, w_gnt_next;
    logic [N_REQ-1:0]  r_done, w_done_next;
    logic              r_err, w_err_next;
    logic [DATA_W-1:0] r_rdata, w_rdata_next;
    logic              r_ptx, w_ptx_next;
    logic              r_write, w_write_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [DATA_W-1:0] r_wdata, w_wdata_next;

    logic [ADDR_W-1:0] w_addr_arr  [N_REQ];
    logic [DATA_W-1:0] w_wdata_arr [N_REQ];
    logic [N_REQ-1:0]  w_win_onehot;
    logic [PTR_W-1:0]  w_win_idx;
    logic              w_any;
    logic              w_complete;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    apb_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_win_onehot),
        .index  (w_win_idx),
        .any    (w_any)
    );

    assign w_complete = bus.PSEL & bus.PENABLE & bus.PREADY;

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_cnt_next   = r_cnt;
        w_gnt_next   = r_gnt;
        w_done_next  = '0;
        w_err_next   = r_err;
        w_rdata_next = r_rdata;
        w_ptx_next   = 1'b0;
        w_write_next = r_write;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;

        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_write_next = req_write[w_win_idx];
                    w_addr_next  = w_addr_arr[w_win_idx];
                    w_wdata_next = w_wdata_arr[w_win_idx];
                    w_gnt_next   = w_win_onehot;
                    w_ptr_next   = w_win_idx;
                    w_ptx_next   = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_next   = '0;
                w_state_next = WAIT;
            end
            WAIT: begin
                // Completion is checked first so it beats a same-cycle timeout.
                if (w_complete) begin
                    w_rdata_next = r_write ? '0 : bus.PRDATA;
                    w_err_next   = 1'b0;
                    w_done_next  = r_gnt;
                    w_state_next = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_rdata_next = '0;
                    w_err_next   = 1'b1;
                    w_done_next  = r_gnt;
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                w_gnt_next   = '0;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
            r_ptr   <= PTR_W'(N_REQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_ptx   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_cnt   <= w_cnt_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_rdata <= w_rdata_next;
            r_ptx   <= w_ptx_next;
            r_write <= w_write_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign bus.PTX   = r_ptx;
    assign bus.WRITE = r_write;
    assign bus.ADDR  = r_addr;
    assign bus.WDATA = r_wdata;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter with a simple APB slave model driven at negedge.
module tb_apb_req_arbiter;
    import apb_arb_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                    PCLK = 1'b0;
    logic                    PRESET;
    logic [N_REQ-1:0]        req, req_write, gnt, done;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic                    err;
    logic [DATA_W-1:0]       rdata;

    apb_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_req_arbiter #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus       (bus.master)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          idx;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] slv_mem [256];
    logic [31:0] ref_mem [256];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ptx_cyc = 0;
    int          slv_phase = 0;
    int          slv_ws_cnt = 0;
    int          cfg_ws = 0;
    bit          cfg_stall = 1'b0;
    logic [31:0] mdl_rdata = '0;
    logic        mdl_err = 1'b0;

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic slv_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hA5A5_A5A5;
        slv_phase   = 0;
    endtask

    task automatic slv_ready();
        bus.PREADY = 1'b1;
        bus.PRDATA = slv_mem[bus.ADDR];
    endtask

    // One clock: sample outputs at negedge, score them, then advance the slave model.
    task automatic tick();
        exp_t             e;
        logic [N_REQ-1:0] oh;
        @(negedge PCLK);
        cyc++;
        if (PRESET) begin
            check("rst_gnt",   64'(gnt), 64'd0);
            check("rst_done",  64'(done), 64'd0);
            check("rst_err",   64'(err), 64'd0);
            check("rst_rdata", 64'(rdata), 64'd0);
            check("rst_ptx",   64'(bus.PTX), 64'd0);
            check("rst_write", 64'(bus.WRITE), 64'd0);
            check("rst_addr",  64'(bus.ADDR), 64'd0);
            check("rst_wdata", 64'(bus.WDATA), 64'd0);
            sb_q.delete();
            mdl_rdata = '0;
            mdl_err   = 1'b0;
            slv_idle();
        end else begin
            if (bus.PTX) begin
                if (sb_q.size() == 0) begin
                    check("ptx_unexpected", 64'd1, 64'd0);
                end else begin
                    e  = sb_q[0];
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("ptx_gnt",    64'(gnt), 64'(oh));
                    check("gnt_onehot", 64'($countones(gnt)), 64'd1);
                    check("ptx_addr",   64'(bus.ADDR), 64'(e.addr));
                    check("ptx_write",  64'(bus.WRITE), 64'(e.wr));
                    if (e.wr) check("ptx_wdata", 64'(bus.WDATA), 64'(e.wdata));
                    ptx_cyc = cyc;
                end
            end
            if (done != '0) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 64'(done), 64'd0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    check("done_onehot", 64'(done), 64'(oh));
                    check("done_gnt",    64'(gnt), 64'(oh));
                    check("done_err",    64'(err), 64'(e.err));
                    check("done_rdata",  64'(rdata), 64'(e.rdata));
                    check("done_lat",    64'(cyc - ptx_cyc), 64'(e.lat));
                    check("done_addr",   64'(bus.ADDR), 64'(e.addr));
                    $display("txn req%0d %s addr=0x%02h wdata=0x%08h rdata=0x%08h err=%0b lat=%0d",
                             e.idx, e.wr ? "WR" : "RD", e.addr, e.wdata, rdata, err, cyc - ptx_cyc);
                    mdl_rdata  = e.rdata;
                    mdl_err    = e.err;
                    req[e.idx] = 1'b0;
                end
            end else begin
                check("hold_rdata", 64'(rdata), 64'(mdl_rdata));
                check("hold_err",   64'(err), 64'(mdl_err));
            end
            case (slv_phase)
                0: if (bus.PTX) begin
                    bus.PSEL  = 1'b1;
                    slv_phase = 1;
                end
                1: begin
                    bus.PENABLE = 1'b1;
                    slv_ws_cnt  = 0;
                    slv_phase   = 2;
                    if (!cfg_stall && cfg_ws == 0) slv_ready();
                end
                default: begin
                    if (bus.PREADY) begin
                        if (bus.WRITE) slv_mem[bus.ADDR] = bus.WDATA;
                        slv_idle();
                    end else if (gnt == '0) begin
                        slv_idle();
                    end else begin
                        slv_ws_cnt++;
                        if (!cfg_stall && slv_ws_cnt >= cfg_ws) slv_ready();
                    end
                end
            endcase
        end
    endtask

    task automatic issue(int i, logic wr, logic [7:0] a, logic [31:0] d);
        exp_t e;
        req_write[i] = wr;
        req_addr[i*ADDR_W +: ADDR_W]  = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
        req[i] = 1'b1;
        e.idx   = i;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = d;
        e.err   = cfg_stall;
        e.lat   = cfg_stall ? TIMEOUT + 1 : 2 + cfg_ws;
        e.rdata = (cfg_stall || wr) ? 32'd0 : ref_mem[a];
        if (wr && !cfg_stall) ref_mem[a] = d;
        sb_q.push_back(e);
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        req    = '0;
        tick();
        PRESET = 1'b0;
        tick();
    endtask

    initial begin
        PRESET    = 1'b1;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int a = 0; a < 256; a++) begin
            slv_mem[a] = '0;
            ref_mem[a] = '0;
        end
        slv_idle();
        tick();
        PRESET = 1'b0;
        tick();

        // Single write from requester 1
        issue(1, 1'b1, 8'h10, 32'hDEADBEEF);
        drain(50);

        // All four requesting after reset: order 0,1,2,3 twice
        do_reset();
        for (int i = 0; i < N_REQ; i++) issue(i, 1'b1, 8'(8'h40 + i), 32'h1000_0000 + i);
        drain(200);
        for (int i = 0; i < N_REQ; i++) issue(i, 1'b0, 8'(8'h40 + i), 32'h0);
        drain(200);

        // Write then read back through requester 2
        issue(2, 1'b1, 8'h20, 32'h12345678);
        drain(50);
        issue(2, 1'b0, 8'h20, 32'h0);
        drain(50);

        // Wait states, including completion on the last permitted WAIT cycle
        cfg_ws = 3;
        issue(3, 1'b0, 8'h10, 32'h0);
        drain(50);
        cfg_ws = TIMEOUT - 1;
        issue(0, 1'b1, 8'h50, 32'h5555_AAAA);
        drain(80);
        cfg_ws = 0;
        issue(0, 1'b0, 8'h50, 32'h0);
        drain(50);

        // Timeout abort, then normal service
        cfg_stall = 1'b1;
        issue(1, 1'b0, 8'h10, 32'h0);
        drain(100);
        cfg_stall = 1'b0;
        issue(1, 1'b0, 8'h10, 32'h0);
        drain(50);

        // Reset during WAIT: no done afterwards, pointer restored
        cfg_stall = 1'b1;
        issue(1, 1'b1, 8'h60, 32'h1111_1111);
        repeat (5) tick();
        do_reset();
        cfg_stall = 1'b0;
        repeat (4) tick();
        issue(0, 1'b1, 8'h70, 32'h7070_0000);
        issue(3, 1'b1, 8'h73, 32'h7373_0000);
        drain(100);
        do_reset();
        issue(3, 1'b0, 8'h73, 32'h0);
        drain(50);

        // Request and data withdrawn mid-transfer: latched values are used
        cfg_ws = 4;
        issue(0, 1'b1, 8'h30, 32'hCAFE_F00D);
        repeat (3) tick();
        req[0] = 1'b0;
        req_addr[0 +: ADDR_W]  = 8'h31;
        req_wdata[0 +: DATA_W] = 32'h0BAD_BEEF;
        drain(50);
        cfg_ws = 0;
        issue(1, 1'b0, 8'h30, 32'h0);
        issue(2, 1'b0, 8'h31, 32'h0);
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
